barrel_rotator: RTL and testbench

//  - Registered 32-bit barrel rotator: rotates a data word left or right by 0..31 bit positions.
//  - No bits are lost: bits shifted out of one end re-enter at the other end.
//  - Generic datapath utility for shift/rotate units, CRC/hash mixing and cipher rounds.
//  - Result is registered, so the block can sit between pipeline stages.

---
 rtl/barrel_rotator_pkg.sv | 12 +
 rtl/barrel_rotator_stage.sv | 33 +++
 rtl/barrel_rotator.sv | 52 +++++
 tb/tb_barrel_rotator.sv | 138 +++++++++++++
 4 files changed

// File: rtl/barrel_rotator_pkg.sv
// Shared definitions for the barrel rotator: direction encoding and parameter sanity helpers.
package barrel_rotator_pkg;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // True when w is a power of two and at least 2.
    function automatic bit is_pow2_ge2(input int w);
        return (w >= 2) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/barrel_rotator_stage.sv
// One rotate stage: rotates by the fixed distance DIST in the selected direction when enabled, else passes through.
// Purely combinational, zero latency, no flow control.
module barrel_rotator_stage
    import barrel_rotator_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] in,
    input  logic             enable,
    input  logic             direction,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] rot_right;
    logic [WIDTH-1:0] rot_left;

    // DIST is always strictly less than WIDTH, so both slices are non-empty.
    assign rot_right = {in[DIST-1:0], in[WIDTH-1:DIST]};
    assign rot_left  = {in[WIDTH-DIST-1:0], in[WIDTH-1:WIDTH-DIST]};

    always_comb begin
        out = in;
        if (enable) begin
            case (direction)
                DIR_RIGHT: out = rot_right;
                DIR_LEFT:  out = rot_left;
                default:   out = in;
            endcase
        end
    end

endmodule

// File: rtl/barrel_rotator.sv
// Registered WIDTH-bit barrel rotator (left/right by 0..WIDTH-1); 1-cycle latency.
// No backpressure: accepts one word per clock whenever in_valid is high.
module barrel_rotator
    import barrel_rotator_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHIFT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHIFT_W-1:0] shift_amount,
    input  logic               direction,
    input  logic               in_valid,
    output logic [WIDTH-1:0]   data_out,
    output logic               out_valid
);

    if (!is_pow2_ge2(WIDTH) || (SHIFT_W != $clog2(WIDTH))) begin : g_bad_params
        $error("barrel_rotator: WIDTH must be a power of two >= 2 and SHIFT_W = clog2(WIDTH)");
    end

    logic [WIDTH-1:0] stage_dat [SHIFT_W+1];

    assign stage_dat[0] = data_in;

    // Stage i rotates by 2**i; the cascade composes any distance 0..WIDTH-1.
    for (genvar i = 0; i < SHIFT_W; i++) begin : g_stage
        barrel_rotator_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << i)
        ) u_stage (
            .in        (stage_dat[i]),
            .enable    (shift_amount[i]),
            .direction (direction),
            .out       (stage_dat[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out <= stage_dat[SHIFT_W];
            end
        end
    end

endmodule

// File: tb/tb_barrel_rotator.sv
// Self-checking bench for barrel_rotator: directed vectors, reset cases, random stream and rotate-inverse property.
module tb_barrel_rotator;

    localparam int WIDTH   = 32;
    localparam int SHIFT_W = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [WIDTH-1:0]   data_in = '0;
    logic [SHIFT_W-1:0] shift_amount = '0;
    logic               direction = 1'b0;
    logic               in_valid = 1'b0;
    logic [WIDTH-1:0]   data_out;
    logic               out_valid;

    int checks   = 0;
    int failures = 0;

    // Reference output state, derived from the behavioural rules only.
    logic [WIDTH-1:0] exp_data = '0;
    logic             exp_vld  = 1'b0;

    barrel_rotator #(
        .WIDTH   (WIDTH),
        .SHIFT_W (SHIFT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .shift_amount (shift_amount),
        .direction    (direction),
        .in_valid     (in_valid),
        .data_out     (data_out),
        .out_valid    (out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_rot(input logic [WIDTH-1:0] d, input int n, input logic left);
        logic [2*WIDTH-1:0] dd;
        dd = {d, d};
        if (n == 0) return d;
        if (left) return dd[2*WIDTH-1-n -: WIDTH];
        return dd[n +: WIDTH];
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the reference model, then compare both outputs.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [WIDTH-1:0] d, input int n, input logic left);
        @(negedge clk);
        rst          = r;
        in_valid     = v;
        data_in      = d;
        shift_amount = SHIFT_W'(n);
        direction    = left;
        @(posedge clk);
        if (r) begin
            exp_data = '0;
            exp_vld  = 1'b0;
        end else if (v) begin
            exp_data = ref_rot(d, n, left);
            exp_vld  = 1'b1;
        end else begin
            exp_vld  = 1'b0;
        end
        #1;
        check({tag, ".data"}, data_out, exp_data);
        check({tag, ".vld"}, {31'b0, out_valid}, {31'b0, exp_vld});
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        int n;
        logic dir;

        // Reset with an input presented: it must be discarded.
        step("rst0", 1'b1, 1'b1, 32'hDEAD_BEEF, 3, 1'b1);
        step("rst1", 1'b1, 1'b1, 32'h0000_0001, 1, 1'b0);
        check("rst_const", data_out, 32'h0);

        // Directed vectors with spec-given constants.
        step("r1",  1'b0, 1'b1, 32'h0000_0001, 1, 1'b0);
        check("r1_const", data_out, 32'h8000_0000);
        step("r31", 1'b0, 1'b1, 32'h0000_0001, 31, 1'b0);
        check("r31_const", data_out, 32'h0000_0002);
        step("r0",  1'b0, 1'b1, 32'h0000_0001, 0, 1'b0);
        check("r0_const", data_out, 32'h0000_0001);
        step("l4",  1'b0, 1'b1, 32'h0000_0001, 4, 1'b1);
        check("l4_const", data_out, 32'h0000_0010);
        step("l31", 1'b0, 1'b1, 32'h0000_0001, 31, 1'b1);
        check("l31_const", data_out, 32'h8000_0000);
        step("l0",  1'b0, 1'b1, 32'h0000_0001, 0, 1'b1);
        check("l0_const", data_out, 32'h0000_0001);
        step("l8",  1'b0, 1'b1, 32'h1234_5678, 8, 1'b1);
        check("l8_const", data_out, 32'h3456_7812);
        step("r8",  1'b0, 1'b1, 32'h1234_5678, 8, 1'b0);
        check("r8_const", data_out, 32'h7812_3456);
        step("l16", 1'b0, 1'b1, 32'h1234_5678, 16, 1'b1);
        check("l16_const", data_out, 32'h5678_1234);
        step("r16", 1'b0, 1'b1, 32'h1234_5678, 16, 1'b0);
        check("r16_const", data_out, 32'h5678_1234);

        // Gap holds data, then mid-stream reset drops the in-flight result.
        step("gap0", 1'b0, 1'b0, 32'hFFFF_FFFF, 5, 1'b1);
        step("pre",  1'b0, 1'b1, 32'hA5A5_0F0F, 7, 1'b0);
        step("mrst", 1'b1, 1'b1, 32'h1111_2222, 9, 1'b1);
        step("post", 1'b0, 1'b1, 32'h8765_4321, 12, 1'b1);

        // Back-to-back random stream with occasional idle cycles.
        for (int i = 0; i < 20; i++) begin
            step("rnd", 1'b0, 1'b1, $urandom, int'($urandom_range(0, 31)), 1'($urandom));
            if ($urandom_range(0, 3) == 0)
                step("rgap", 1'b0, 1'b0, $urandom, int'($urandom_range(0, 31)), 1'($urandom));
        end

        // Left by n then right by n restores the word.
        for (int k = 0; k < WIDTH; k++) begin
            w   = $urandom;
            n   = k;
            dir = 1'b1;
            step("inv_l", 1'b0, 1'b1, w, n, dir);
            step("inv_r", 1'b0, 1'b1, data_out, n, 1'b0);
            check("inv_word", data_out, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
